quan_pe_tile_sched: RTL
=======================

QUAN_PE_TILE_SCHED -- requirements
Module: quan_pe_tile_sched

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
  ROWS, 4, PE array rows (drain beats per tile)
  COLS, 4, PE array columns
  MAC_LAT, 3, cycles from MAC operand input to valid accumulator output
  K_W, 10, width of the accumulation-length field
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk  in  1  single clock, rising edge
  reset  in  1  synchronous, active-low
  start  in  1  one-cycle tile launch request, sampled in IDLE only
  cfg_mode  in  4  PE precision mode, latched on accepted start
  cfg_k  in  K_W  operand beats per tile, latched on accepted start
  in_valid  in  1  operand feeder has one skewed column vector
  in_ready  out  1  scheduler accepts operand beat
  arr_en  out  1  array shift/MAC enable
  arr_zero  out  1  array shall inject zero operands this cycle
  pe_clr  out  1  accumulator clear, to array reset path
  pe_mode  out  4  registered mode to all PEs
  out_row  out  clog2(ROWS)  row index being drained
  out_valid  out  1  drained row result valid
  out_ready  in  1  downstream accepts row result
  busy  out  1  high in every state except IDLE
  done  out  1  one-cycle tile-complete pulse
  err  out  1  one-cycle pulse: start with cfg_k==0

Function
REQ-003 The FSM SHALL have states IDLE, CLEAR, FEED, FLUSH, DRAIN and DONE.
REQ-004 In IDLE, start=1 with cfg_k!=0 SHALL latch cfg_mode and cfg_k and enter CLEAR the next cycle.
REQ-005 In IDLE, start=1 with cfg_k==0 SHALL enter DONE and pulse err in that same DONE cycle; no CLEAR, FEED or DRAIN occurs.
REQ-006 The scheduler SHALL ignore start outside IDLE, with no latch and no effect.
REQ-007 pe_mode SHALL update only on an accepted start and SHALL hold for the whole tile.
REQ-008 CLEAR SHALL last exactly 1 cycle with pe_clr=1, then go to FEED.
REQ-009 In FEED, in_ready=1 and arr_en=in_valid; a beat SHALL count only on in_valid&&in_ready.
REQ-010 When the cfg_k-th beat is accepted, FEED SHALL transition to FLUSH on the next cycle.
REQ-011 in_valid low stalls in FEED SHALL freeze the array (arr_en=0) and SHALL not count as beats.
REQ-012 FLUSH SHALL last exactly ROWS+COLS-2+MAC_LAT cycles with arr_en=1, arr_zero=1 and in_ready=0, then go to DRAIN.
REQ-013 In DRAIN, out_valid=1 and out_row starts at 0.
REQ-014 In DRAIN, out_row SHALL increment on out_valid&&out_ready.
REQ-015 While out_ready=0 in DRAIN, out_valid and out_row SHALL hold stable.
REQ-016 DRAIN SHALL exit to DONE after the handshake with out_row==ROWS-1.
REQ-017 DONE SHALL last 1 cycle with done=1, then go to IDLE; a start in that DONE cycle SHALL be ignored.
REQ-018 The beat counter SHALL be K_W bits and compare against the latched cfg_k, so the maximum cfg_k of 2^K_W-1 completes with no wrap.
REQ-019 All outputs SHALL be registered or decoded from state only; in_ready and arr_en may depend on in_valid combinationally.
REQ-020 arr_en and pe_clr SHALL never both be 1 in the same cycle.

Reset
REQ-021 When reset=0 at a clk edge, the block SHALL enter IDLE with every counter at 0.
REQ-022 Reset values SHALL be: in_ready=0, arr_en=0, arr_zero=0, pe_clr=0, pe_mode=0, out_row=0, out_valid=0, busy=0, done=0, err=0.
REQ-023 Reset asserted mid-tile SHALL abort the tile with no done pulse; the next tile SHALL start from CLEAR.

Structure
REQ-024 State encoding and the FLUSH length expression SHALL live in a shared package quan_sched_pkg.
REQ-025 The beat and flush counting SHALL be one sub-module, quan_sched_cnt (a loadable down-counter with a zero flag), instantiated twice.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
  Nominal: ROWS=COLS=4, MAC_LAT=3, cfg_k=8, in_valid=1 always, out_ready=1 -> pe_clr 1 cycle, 8 arr_en beats, 9 FLUSH cycles, out_row 0..3, done at cycle 1+1+8+9+4+1=24 after start.
  Stall: cfg_k=4 with in_valid low for 3 cycles mid-feed -> exactly 4 arr_en beats in FEED, done 3 cycles later than with no stall.
  Backpressure: out_ready low for 5 cycles at out_row=2 -> out_row held at 2, out_valid held 1, no skipped row.
  Zero length: start with cfg_k=0 -> err and done both pulse 1 cycle after start, pe_clr never asserts.
  Ignored start: start pulsed during FEED with cfg_mode=4'hF -> pe_mode unchanged, beat count unchanged.
  Abort: reset=0 during FLUSH -> all outputs at reset values the next cycle, no done; a following cfg_k=2 tile completes normally.

Source files
------------

// File: rtl/quan_sched_pkg.sv
// ---------------------------------------------------------------------------
// quan_sched_pkg
// Shared definitions for the PE tile scheduler: FSM state encoding and the
// FLUSH length, which is the time for the last operand beat to ripple
// through the skewed array and the MAC pipeline.
// ---------------------------------------------------------------------------
package quan_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_FEED  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DRAIN = 3'd4,
        ST_DONE  = 3'd5
    } sched_state_e;

    // Zero-operand cycles needed after the last real beat: the skew across
    // rows and columns plus the MAC latency.
    function automatic int flush_len(input int rows, input int cols, input int mac_lat);
        return rows + cols - 2 + mac_lat;
    endfunction

endpackage

// File: rtl/quan_sched_cnt.sv
// ---------------------------------------------------------------------------
// quan_sched_cnt
// Loadable down-counter with a zero flag. Load wins over decrement; the
// counter never decrements below zero.
// Ports:
//   clk, reset   clock, synchronous active-low reset (count -> 0)
//   ld, ld_val   load the count with ld_val
//   dec          decrement by one when non-zero
//   zero         count is zero
// ---------------------------------------------------------------------------
module quan_sched_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (ld)
            cnt_d = ld_val;
        else if (dec && cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/quan_pe_tile_sched.sv
// ---------------------------------------------------------------------------
// quan_pe_tile_sched
// Sequences one tile through a ROWS x COLS quantized PE array:
// clear accumulators, feed cfg_k operand beats (stalling on in_valid),
// flush the pipeline with zero operands, drain ROWS row results with
// backpressure, then pulse done.
// Ports:
//   clk, reset            clock, synchronous active-low reset
//   start, cfg_mode,      tile launch; mode and length latched on an
//   cfg_k                 accepted start (IDLE only, cfg_k != 0)
//   in_valid / in_ready   operand beat handshake (FEED only)
//   arr_en, arr_zero      array enable / inject zeros (FLUSH)
//   pe_clr, pe_mode       accumulator clear, held precision mode
//   out_row, out_valid,   row drain handshake
//   out_ready
//   busy, done, err       status; err flags a zero-length start
// ---------------------------------------------------------------------------
module quan_pe_tile_sched
    import quan_sched_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 4,
    parameter int MAC_LAT = 3,
    parameter int K_W     = 10,
    localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       cfg_mode,
    input  logic [K_W-1:0]   cfg_k,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             arr_en,
    output logic             arr_zero,
    output logic             pe_clr,
    output logic [3:0]       pe_mode,
    output logic [ROW_W-1:0] out_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int FLUSH_LEN = flush_len(ROWS, COLS, MAC_LAT);
    localparam int FL_W      = $clog2(FLUSH_LEN + 1);

    sched_state_e     state_q, state_d;
    logic [ROW_W-1:0] out_row_q, out_row_d;
    logic [3:0]       pe_mode_q, pe_mode_d;
    logic             err_q, err_d;

    logic beat, beat_ld, beat_zero;
    logic fl_ld, fl_dec, fl_zero;

    assign beat   = (state_q == ST_FEED) && in_valid;
    assign fl_dec = (state_q == ST_FLUSH);

    // Beat counter holds beats remaining minus one, so the zero flag marks
    // the final beat and the full K_W range is usable without wrap.
    quan_sched_cnt #(.W(K_W)) u_beat_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (beat_ld),
        .ld_val (cfg_k - 1'b1),
        .dec    (beat),
        .zero   (beat_zero)
    );

    quan_sched_cnt #(.W(FL_W)) u_flush_cnt (
        .clk    (clk),
        .reset  (reset),
        .ld     (fl_ld),
        .ld_val (FL_W'(FLUSH_LEN - 1)),
        .dec    (fl_dec),
        .zero   (fl_zero)
    );

    always_comb begin
        state_d   = state_q;
        out_row_d = out_row_q;
        pe_mode_d = pe_mode_q;
        err_d     = 1'b0;
        beat_ld   = 1'b0;
        fl_ld     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (cfg_k != '0) begin
                        state_d   = ST_CLEAR;
                        pe_mode_d = cfg_mode;
                        beat_ld   = 1'b1;
                    end else begin
                        // Zero-length tile: skip straight to DONE, flag err there.
                        state_d = ST_DONE;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_CLEAR: state_d = ST_FEED;
            ST_FEED: begin
                if (beat && beat_zero) begin
                    state_d = ST_FLUSH;
                    fl_ld   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fl_zero) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    if (out_row_q == ROW_W'(ROWS - 1)) begin
                        state_d   = ST_DONE;
                        out_row_d = '0;
                    end else begin
                        out_row_d = out_row_q + 1'b1;
                    end
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            out_row_q <= '0;
            pe_mode_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            out_row_q <= out_row_d;
            pe_mode_q <= pe_mode_d;
            err_q     <= err_d;
        end
    end

    // Outputs decode from state; only FEED's enable looks at in_valid.
    assign in_ready  = (state_q == ST_FEED);
    assign arr_en    = beat || (state_q == ST_FLUSH);
    assign arr_zero  = (state_q == ST_FLUSH);
    assign pe_clr    = (state_q == ST_CLEAR);
    assign pe_mode   = pe_mode_q;
    assign out_row   = out_row_q;
    assign out_valid = (state_q == ST_DRAIN);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;

endmodule
